// File: rtl/ep2_cipher_lane_engine.sv
// Multi-lane AXIS front end for a fixed-latency cipher core array: beat slicing, credit
// flow control toward a non-stallable core, and in-order reassembly of the results.

module ep2_cle_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH+1);

   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic            do_push;
   logic            do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push = push && (count != CNTW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage array, contents need no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

module ep2_cipher_lane_engine #(
   parameter int DATA_WIDTH   = 512,
   parameter int KEEP_WIDTH   = DATA_WIDTH/8,
   parameter int LANES        = 1,
   parameter int CORE_LATENCY = 29,
   parameter int KEY_SEL_W    = 2,
   parameter int OUT_DEPTH    = 64,
   parameter int SIDE_DEPTH   = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
   input  logic [KEY_SEL_W-1:0]           s_axis_tuser,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic [128*LANES-1:0]           core_in_data,
   output logic [KEY_SEL_W-1:0]           core_key_sel,
   output logic                           core_in_valid,
   input  logic [128*LANES-1:0]           core_out_data,
   output logic [31:0]                    stat_pkts_in,
   output logic [31:0]                    stat_pkts_out,
   output logic [$clog2(OUT_DEPTH+1)-1:0] credit_level
);
   localparam int CW     = 128*LANES;
   localparam int NCHUNK = DATA_WIDTH / CW;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int RLW    = $clog2(OUT_DEPTH+1);
   localparam int SLW    = $clog2(SIDE_DEPTH+1);

   logic                    hold_valid;
   logic [DATA_WIDTH-1:0]   hold_data;
   logic [KEY_SEL_W-1:0]    hold_key;
   logic [KEY_SEL_W-1:0]    pkt_key;
   logic                    pkt_start;
   logic [IW-1:0]           chunk_idx;
   logic [IW-1:0]           asm_idx;
   logic [CORE_LATENCY-1:0] vld_pipe;

   logic                    issue;
   logic                    last_issue;
   logic                    s_ready;
   logic                    s_fire;
   logic                    m_fire;
   logic                    res_pop;
   logic                    asm_last;
   logic                    side_full;
   logic                    side_empty;
   logic                    res_empty;
   logic [CW-1:0]           res_rdata;
   logic [RLW-1:0]          res_level;
   logic [KEEP_WIDTH:0]     side_rdata;
   logic [SLW-1:0]          side_level;

   assign side_full  = (side_level == SLW'(SIDE_DEPTH));
   assign side_empty = (side_level == '0);
   assign res_empty  = (res_level == '0);

   assign issue      = hold_valid && (credit_level != '0);
   assign last_issue = issue && (chunk_idx == IW'(NCHUNK-1));
   assign s_ready    = !rst && !side_full && (!hold_valid || last_issue);
   assign s_fire     = s_axis_tvalid && s_ready;
   assign m_fire     = m_axis_tvalid && m_axis_tready;

   // the beat-completing pop also needs its sideband, which always precedes the results
   assign res_pop  = !res_empty && (!m_axis_tvalid || m_axis_tready) &&
                     ((asm_idx != IW'(NCHUNK-1)) || !side_empty);
   assign asm_last = res_pop && (asm_idx == IW'(NCHUNK-1));

   assign s_axis_tready = s_ready;
   assign core_in_valid = issue;
   assign core_key_sel  = hold_key;
   assign core_in_data  = hold_data[chunk_idx*CW +: CW];

   // hold register, packet key latch and chunk issue index
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         hold_key   <= '0;
         pkt_key    <= '0;
         pkt_start  <= 1'b1;
         chunk_idx  <= '0;
      end else begin
         if (s_fire) begin
            hold_valid <= 1'b1;
            hold_data  <= s_axis_tdata;
            hold_key   <= pkt_start ? s_axis_tuser : pkt_key;
            pkt_start  <= s_axis_tlast;
            if (pkt_start) pkt_key <= s_axis_tuser;
         end else if (last_issue) begin
            hold_valid <= 1'b0;
         end
         if (issue) chunk_idx <= last_issue ? '0 : chunk_idx + 1'b1;
      end
   end

   // credits track free result-FIFO slots not yet claimed by in-flight chunks
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_level <= RLW'(OUT_DEPTH);
         vld_pipe     <= '0;
      end else begin
         vld_pipe <= (vld_pipe << 1) | CORE_LATENCY'(issue);
         case ({issue, res_pop})
            2'b10:   credit_level <= credit_level - 1'b1;
            2'b01:   credit_level <= credit_level + 1'b1;
            default: credit_level <= credit_level;
         endcase
      end
   end

   ep2_cle_fifo #(.W(CW), .DEPTH(OUT_DEPTH)) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vld_pipe[CORE_LATENCY-1]),
      .wdata (core_out_data),
      .pop   (res_pop),
      .rdata (res_rdata),
      .level (res_level)
   );

   ep2_cle_fifo #(.W(KEEP_WIDTH+1), .DEPTH(SIDE_DEPTH)) u_side_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_fire),
      .wdata ({s_axis_tkeep, s_axis_tlast}),
      .pop   (asm_last),
      .rdata (side_rdata),
      .level (side_level)
   );

   // output assembler: fills slots in order, presents the beat once the last slot lands
   always_ff @(posedge clk) begin
      if (rst) begin
         asm_idx       <= '0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else begin
         if (res_pop) begin
            m_axis_tdata[asm_idx*CW +: CW] <= res_rdata;
            asm_idx <= asm_last ? '0 : asm_idx + 1'b1;
         end
         if (asm_last) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tkeep  <= side_rdata[KEEP_WIDTH:1];
            m_axis_tlast  <= side_rdata[0];
         end else if (m_fire) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   // packet counters on both ports
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkts_in  <= '0;
         stat_pkts_out <= '0;
      end else begin
         if (s_fire && s_axis_tlast) stat_pkts_in  <= stat_pkts_in + 32'd1;
         if (m_fire && m_axis_tlast) stat_pkts_out <= stat_pkts_out + 32'd1;
      end
   end
endmodule
